weight_bank_ctrl: RTL
=====================

# weight_bank_ctrl

Parametrised, prefetching weight-bank controller for the convolution core. It holds the active set of `NUM_KERNELS` kernels (each `KERNEL_SIZE` weights) on `weights_out`, and issues loads to the weight loader ahead of need. Up to `DEPTH` future sets are stored in an internal prefetch queue, so a channel switch normally costs zero stall cycles. It sits between the weight loader and the pipeline's end gate, and reports starvation explicitly.

## Interface
- `WEIGHT_WIDTH`, 8, bits per weight
- `KERNEL_SIZE`, 9, weights per kernel
- `NUM_KERNELS`, 4, kernels per set
- `DEPTH`, 2, prefetch queue entries (≥1)
- SET_W = NUM_KERNELS·KERNEL_SIZE·WEIGHT_WIDTH; LW = $clog2(DEPTH+1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `init`  in  1  start pulse, honoured only in IDLE
- `flush`  in  1  abort the layer; return to IDLE from any state
- `load_done`  in  1  one-cycle pulse; `weights_in` valid this cycle
- `weights_in`  in  SET_W  set from loader, kernel 0 in LSBs
- `channel_end`  in  1  current channel finished
- `core_free`  in  1  core can accept new weights
- `weights_out`  out  SET_W  active set
- `buffer_ready`  out  1  `weights_out` valid for compute
- `load_start`  out  1  one-cycle load request to loader
- `fill_level`  out  LW  queued prefetched sets
- `state`  out  2  FSM state
- `overflow_err`  out  1  sticky; `load_done` arrived with no outstanding request
- `stall_cycles`  out  16  see Configuration

## Operation
- States: IDLE=0, FILL=1, RUN=2, STARVE=3.
- Swap event: `channel_end & core_free`. It is acted on only in RUN.
- Outstanding flag `pend`:
  - Set when `load_start` is issued.
  - Cleared on `load_done`.
  - At most one load is in flight.
- Request rule (not IDLE): `load_start`=1 when `!pend && !load_start && (fill_level + (state==FILL||state==STARVE ? 0 : 0)) < DEPTH`. In FILL and STARVE, the request is for the active set.
- IDLE: `init` → FILL and `load_start`=1. Other inputs are ignored.
- FILL: `load_done` → `weights_out`←`weights_in`, `buffer_ready`←1, → RUN.
- RUN, swap event:
  - fill_level>0: `weights_out`←queue head, pop.
  - fill_level==0 with simultaneous `load_done`: bypass `weights_in` to `weights_out`, stay in RUN.
  - fill_level==0 without `load_done`: `buffer_ready`←0, → STARVE.
- RUN, `load_done` without a swap event: push to the queue.
- RUN, push and pop in the same cycle: `fill_level` is unchanged; FIFO order is preserved (head out, new data at tail).
- STARVE: `load_done` → `weights_out`←`weights_in`, `buffer_ready`←1, → RUN. Swap events are ignored.
- Protocol error: `load_done` with `pend`=0 or in IDLE is discarded and sets `overflow_err`. The flag is cleared only by reset.
- `flush` (highest priority, any state):
  - → IDLE, `fill_level`←0, `buffer_ready`←0.
  - `weights_out` is held.
  - If `pend` was set, the corresponding later `load_done` is discarded silently (`drop` flag), with no error.
- `init` outside IDLE is ignored.

## Timing
- All outputs are registered. Reset values:
  - `state`=IDLE
  - `weights_out`=0
  - `buffer_ready`=0
  - `load_start`=0
  - `fill_level`=0
  - `overflow_err`=0
  - `stall_cycles`=0
  - internal `pend` and `drop` = 0
- `load_start` rises the cycle after `init` is sampled and lasts exactly 1 cycle.
- Refills are requested back-to-back: the next `load_start` comes 1 cycle after the `load_done` that cleared `pend`, if space remains.
- Swap latency: `weights_out` and `fill_level` update on the edge that samples the swap event.
- STARVE exit: `buffer_ready` rises on the edge that samples `load_done`.
- Asynchronous reset mid-load clears everything immediately. A `load_done` arriving after reset with `pend`=0 sets `overflow_err`.

## Configuration
- `WEIGHT_BANK_STATS_EN` defined: `stall_cycles` increments each cycle `state==STARVE`, saturates at 16'hFFFF, and clears on reset or on `init` accepted in IDLE.
- `WEIGHT_BANK_STATS_EN` not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- Startup: pulse `init`; loader returns `load_done` 5 cycles after each `load_start`, with sets A, B, C.
  - `load_start` at t+1; `buffer_ready`=1 with `weights_out`=A.
  - Then B and C are queued; `fill_level`=2 and no further `load_start` (DEPTH=2).
- Zero-stall swap: from the full queue, issue 2 swap events 1 cycle apart.
  - `weights_out`=B, then C; `fill_level` 1 then 0; `buffer_ready` stays 1.
  - Refill `load_start` issued.
- Starvation: issue a swap with `fill_level`=0 and `load_done` 7 cycles later.
  - STARVE with `buffer_ready`=0 for 7 cycles; RUN on the done edge.
  - `stall_cycles`=7 with the macro, 0 without.
- Simultaneous events:
  - Swap and `load_done` with `fill_level`=0: bypass, state stays RUN.
  - Swap and `load_done` with `fill_level`=1: level stays 1 and the head is output.
- Flush mid-load: `flush` while `pend`=1, then `load_done`.
  - IDLE, `fill_level`=0, data dropped, `overflow_err`=0.
  - A second unsolicited `load_done` sets `overflow_err`=1.
- Reset: deassert `rst_n` asynchronously in RUN. All outputs go to their reset values immediately, and `init` restarts cleanly.

Source files
------------

// File: rtl/weight_bank_ctrl.sv
// Prefetching weight-bank controller: holds the active kernel set and keeps up to DEPTH future sets queued.
// Optional stall statistics are built when WEIGHT_BANK_STATS_EN is defined.
module weight_bank_ctrl #(
    parameter  int unsigned WEIGHT_WIDTH = 8,
    parameter  int unsigned KERNEL_SIZE  = 9,
    parameter  int unsigned NUM_KERNELS  = 4,
    parameter  int unsigned DEPTH        = 2,
    localparam int unsigned SET_W        = NUM_KERNELS * KERNEL_SIZE * WEIGHT_WIDTH,
    localparam int unsigned LW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             flush,
    input  logic             load_done,
    input  logic [SET_W-1:0] weights_in,
    input  logic             channel_end,
    input  logic             core_free,
    output logic [SET_W-1:0] weights_out,
    output logic             buffer_ready,
    output logic             load_start,
    output logic [LW-1:0]    fill_level,
    output logic [1:0]       state,
    output logic             overflow_err,
    output logic [15:0]      stall_cycles
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2,
        STARVE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              pend, drop;
    logic [SET_W-1:0]  mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;

    logic swap, ld_accept, ld_drop, ld_err;
    logic load_active, bypass, pop, push, starve_enter, req;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (init)         state_d = FILL;
                FILL:    if (ld_accept)    state_d = RUN;
                RUN:     if (starve_enter) state_d = STARVE;
                STARVE:  if (ld_accept)    state_d = RUN;
                default:                   state_d = IDLE;
            endcase
        end
    end

    // Control decode; pend and drop are mutually exclusive because requests wait for drop to clear
    always_comb begin
        swap         = channel_end & core_free;
        ld_accept    = load_done & pend;
        ld_drop      = load_done & drop;
        ld_err       = load_done & ~pend & ~drop;
        load_active  = 1'b0;
        bypass       = 1'b0;
        pop          = 1'b0;
        push         = 1'b0;
        starve_enter = 1'b0;
        req          = 1'b0;
        if (!flush) begin
            load_active  = (state_q == FILL || state_q == STARVE) && ld_accept;
            bypass       = (state_q == RUN) && swap && (fill_level == '0) && ld_accept;
            pop          = (state_q == RUN) && swap && (fill_level != '0);
            starve_enter = (state_q == RUN) && swap && (fill_level == '0) && !ld_accept;
            push         = (state_q == RUN) && ld_accept && !bypass &&
                           ((fill_level < LW'(DEPTH)) || pop);
            req          = ((state_q == IDLE) ? init : 1'b1) && !pend && !drop &&
                           !load_start && (fill_level < LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_out  <= '0;
            buffer_ready <= 1'b0;
            load_start   <= 1'b0;
            fill_level   <= '0;
            overflow_err <= 1'b0;
            pend         <= 1'b0;
            drop         <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            load_start <= req;
            if (ld_err) overflow_err <= 1'b1;
            if (flush) begin
                buffer_ready <= 1'b0;
                fill_level   <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                pend         <= 1'b0;
                drop         <= (drop | pend) & ~load_done;
            end else begin
                if (req)            pend <= 1'b1;
                else if (ld_accept) pend <= 1'b0;
                if (ld_drop) drop <= 1'b0;

                if (load_active || bypass) weights_out <= weights_in;
                else if (pop)              weights_out <= mem[rd_ptr];

                if (load_active)       buffer_ready <= 1'b1;
                else if (starve_enter) buffer_ready <= 1'b0;

                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);

                case ({push, pop})
                    2'b10:   fill_level <= fill_level + LW'(1);
                    2'b01:   fill_level <= fill_level - LW'(1);
                    default: fill_level <= fill_level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= weights_in;
    end

`ifdef WEIGHT_BANK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (state_q == IDLE && init && !flush)
            stall_cycles <= '0;
        else if (state_q == STARVE && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
